// File: rtl/gate_tester.sv
// Two-input gate tester: drives the four input vectors to an external gate, samples
// its response after a settle time and reports per-vector mismatches and a pass flag.
module gate_tester #(
  parameter int unsigned SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] gate_sel,
  output logic       in1,
  output logic       in2,
  input  logic       out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] mismatch,
  output logic [2:0] err_count
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in1_q;
  logic             in2_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [3:0]       mism_q;
  logic [2:0]       err_q;
  logic [1:0]       vec_c;
  logic             exp_c;

  assign vec_c = {in1_q, in2_q};

  // Expected response of the latched gate function for the vector currently driven.
  always_comb begin
    exp_c = 1'b0;
    case (sel_q)
      3'd0:    exp_c = in1_q & in2_q;
      3'd1:    exp_c = in1_q | in2_q;
      3'd2:    exp_c = ~(in1_q & in2_q);
      3'd3:    exp_c = ~(in1_q | in2_q);
      3'd4:    exp_c = in1_q ^ in2_q;
      3'd5:    exp_c = ~(in1_q ^ in2_q);
      default: exp_c = 1'b0;
    endcase
  end

  // cnt_q counts down the settle window; the response is sampled as it leaves 1 and
  // the next vector is launched one edge later, when it has reached 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      cnt_q   <= '0;
      in1_q   <= 1'b0;
      in2_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mism_q  <= 4'd0;
      err_q   <= 3'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sel_q  <= gate_sel;
            pass_q <= 1'b0;
            busy_q <= 1'b1;
            in1_q  <= 1'b0;
            in2_q  <= 1'b0;
            if (gate_sel <= 3'd5) begin
              mism_q  <= 4'd0;
              err_q   <= 3'd0;
              cnt_q   <= CNT_W'(SETTLE);
              state_q <= RUN;
            end else begin
              // Unknown gate function: report every vector as failed without driving any.
              mism_q  <= 4'b1111;
              err_q   <= 3'd4;
              state_q <= DONE;
            end
          end
        end
        RUN: begin
          if (cnt_q == CNT_W'(0)) begin
            {in1_q, in2_q} <= vec_c + 2'd1;
            cnt_q          <= CNT_W'(SETTLE);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              if (out != exp_c) begin
                mism_q[vec_c] <= 1'b1;
                err_q         <= err_q + 3'd1;
              end
              if (vec_c == 2'd3) begin
                state_q <= DONE;
              end
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          pass_q  <= (mism_q == 4'd0);
          in1_q   <= 1'b0;
          in2_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in1       = in1_q;
  assign in2       = in2_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign mismatch  = mism_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_gate_tester.sv
// Directed bench for gate_tester (SETTLE=4) against a behavioural gate with optional stuck-at-1.
module tb_gate_tester;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] gate_sel;
  logic       in1;
  logic       in2;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] mismatch;
  logic [2:0] err_count;

  logic [2:0] model_gate;
  logic       stuck1;

  int n_cmp;
  int n_bad;

  gate_tester #(.SETTLE(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .gate_sel  (gate_sel),
    .in1       (in1),
    .in2       (in2),
    .out       (dut_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .mismatch  (mismatch),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural gate under test.
  always_comb begin
    dut_out = 1'b0;
    case (model_gate)
      3'd0: dut_out = in1 & in2;
      3'd1: dut_out = in1 | in2;
      3'd2: dut_out = ~(in1 & in2);
      3'd3: dut_out = ~(in1 | in2);
      3'd4: dut_out = in1 ^ in2;
      3'd5: dut_out = ~(in1 ^ in2);
      default: dut_out = 1'b0;
    endcase
    if (stuck1) dut_out = 1'b1;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".in"}, 8'({in1, in2}), 8'd0);
    chk({tag, ".busy"}, 8'(busy), 8'd0);
    chk({tag, ".done"}, 8'(done), 8'd0);
  endtask

  // Called at a negedge. exp_at is the cycle after T0 carrying done; poke re-pulses
  // start at T0+7 and changes gate_sel at T0+8.
  task automatic run_test(input logic [2:0] sel, input int exp_at, input bit poke,
                          input logic exp_pass, input logic [3:0] exp_mism,
                          input logic [2:0] exp_err);
    int exp_vec;
    start    = 1'b1;
    gate_sel = sel;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < exp_at + 6; n++) begin
      @(negedge clk);
      exp_vec = (exp_at == 20 && n < 20) ? n / 5 : 0;
      chk("vec", 8'({in1, in2}), 8'(exp_vec));
      chk("busy", 8'(busy), 8'(n < exp_at));
      chk("done", 8'(done), 8'(n == exp_at));
      if (n == exp_at) begin
        chk("pass", 8'(pass), 8'(exp_pass));
        chk("mismatch", 8'(mismatch), 8'(exp_mism));
        chk("err_count", 8'(err_count), 8'(exp_err));
      end
      if (poke && n == 6) start = 1'b1;
      if (poke && n == 7) begin
        start    = 1'b0;
        gate_sel = 3'd0;
      end
    end
    chk("pass_hold", 8'(pass), 8'(exp_pass));
    chk("mismatch_hold", 8'(mismatch), 8'(exp_mism));
    chk("err_hold", 8'(err_count), 8'(exp_err));
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    gate_sel   = 3'd0;
    model_gate = 3'd2;
    stuck1     = 1'b0;

    // Reset held, then released with no start.
    repeat (3) @(negedge clk);
    chk_idle_outputs("rst");
    chk("rst.pass", 8'(pass), 8'd0);
    chk("rst.mismatch", 8'(mismatch), 8'd0);
    chk("rst.err", 8'(err_count), 8'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_outputs("post_rst");
    chk("post_rst.pass", 8'(pass), 8'd0);

    // Ideal NAND.
    run_test(3'd2, 20, 1'b0, 1'b1, 4'b0000, 3'd0);
    // NAND stuck at 1: only vector 11 disagrees.
    stuck1 = 1'b1;
    run_test(3'd2, 20, 1'b0, 1'b0, 4'b1000, 3'd1);
    stuck1 = 1'b0;
    // Expect AND, DUT is NAND: every vector fails.
    run_test(3'd0, 20, 1'b0, 1'b0, 4'b1111, 3'd4);
    // Invalid gate selects.
    run_test(3'd7, 1, 1'b0, 1'b0, 4'b1111, 3'd4);
    run_test(3'd6, 1, 1'b0, 1'b0, 4'b1111, 3'd4);
    // Expect XNOR, DUT is AND: only vector 00 disagrees.
    model_gate = 3'd0;
    run_test(3'd5, 20, 1'b0, 1'b0, 4'b0001, 3'd1);
    // Expect OR, DUT is XOR: only vector 11 disagrees.
    model_gate = 3'd4;
    run_test(3'd1, 20, 1'b0, 1'b0, 4'b1000, 3'd1);
    // Ideal XOR with start re-pulse and gate_sel change mid-run.
    run_test(3'd4, 20, 1'b1, 1'b1, 4'b0000, 3'd0);

    // NOR run aborted by asynchronous reset just before T0+9.
    model_gate = 3'd3;
    start      = 1'b1;
    gate_sel   = 3'd3;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n <= 8; n++) @(negedge clk);
    chk("abort.busy_before", 8'(busy), 8'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_idle_outputs("abort");
    chk("abort.pass", 8'(pass), 8'd0);
    chk("abort.mismatch", 8'(mismatch), 8'd0);
    chk("abort.err", 8'(err_count), 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      chk_idle_outputs("abort_after");
    end
    run_test(3'd3, 20, 1'b0, 1'b1, 4'b0000, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
